// File: rtl/monitor_capture_demux_pkg.sv
// Shared definitions for the capture-stream demultiplexer.
package monitor_capture_demux_pkg;

  // Packet counter width (counters wrap naturally).
  localparam int CNT_W = 16;

  // Skid buffer depth per output.
  localparam int SKID_DEPTH = 2;

  // Payload bit layout, MSB to LSB: {data, empty, eop, sop}.
  localparam int FLD_SOP   = 0;
  localparam int FLD_EOP   = 1;
  localparam int FLD_EMPTY = 2;

  // Route state: between packets, or inside a packet with dest latched.
  typedef enum logic {
    RT_IDLE = 1'b0,
    RT_PKT  = 1'b1
  } route_state_e;

  // Width of one buffered beat: data + empty + eop + sop.
  function automatic int payload_width(input int data_w, input int empty_w);
    return data_w + empty_w + 2;
  endfunction

endpackage

// File: rtl/monitor_capture_demux_skid.sv
// Two-entry skid FIFO: accepts a beat every cycle while not full, so one
// cycle of downstream stall never creates a bubble.
module monitor_capture_demux_skid
  import monitor_capture_demux_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic [1:0]               count
);

  logic [SKID_DEPTH-1:0][PAYLOAD_WIDTH-1:0] mem;
  logic                                     wr_ptr;
  logic                                     rd_ptr;
  logic [1:0]                               cnt;
  logic                                     wr;
  logic                                     rd;

  assign in_ready    = (cnt < 2'd2);
  assign out_valid   = (cnt != 2'd0);
  assign out_payload = mem[rd_ptr];
  assign count       = cnt;
  assign wr          = in_valid && in_ready;
  assign rd          = out_valid && out_ready;

  // Storage, pointers and occupancy; read+write together keeps count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= in_payload;
        wr_ptr      <= !wr_ptr;
      end
      if (rd) rd_ptr <= !rd_ptr;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/monitor_capture_demux.sv
// Routes whole Avalon-ST packets to one of two outputs by the channel seen
// at packet start; counts delivered packets and flags framing violations.
module monitor_capture_demux
  import monitor_capture_demux_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_channel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [DATA_WIDTH-1:0]  out0_data,
  output logic                   out0_startofpacket,
  output logic                   out0_endofpacket,
  output logic [EMPTY_WIDTH-1:0] out0_empty,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [DATA_WIDTH-1:0]  out1_data,
  output logic                   out1_startofpacket,
  output logic                   out1_endofpacket,
  output logic [EMPTY_WIDTH-1:0] out1_empty,
  output logic [CNT_W-1:0]       pkt_count0,
  output logic [CNT_W-1:0]       pkt_count1,
  output logic                   framing_err
);

  localparam int PW = payload_width(DATA_WIDTH, EMPTY_WIDTH);

  route_state_e           state;
  route_state_e           state_nxt;
  logic                   dest;
  logic                   sel;
  logic                   accept;
  logic [PW-1:0]          in_payload;
  logic [1:0][1:0]        buf_cnt;
  logic [1:0]             buf_rdy;
  logic [1:0]             buf_wr;
  logic [1:0]             buf_vld;
  logic [1:0]             buf_out_rdy;
  logic [1:0][PW-1:0]     buf_out;
  logic [1:0][CNT_W-1:0]  pkt_cnt;
  logic                   ferr;

  // A SOP beat always re-selects the channel, even mid-packet, so a
  // malformed stream resynchronises on the next start.
  assign sel         = (state == RT_IDLE || in_startofpacket) ? in_channel : dest;
  // Ready looks only at the selected buffer's occupancy; output ready is
  // deliberately not in this path (the skid absorbs it).
  assign in_ready    = !reset && (buf_cnt[sel] < 2'd2);
  assign accept      = in_valid && in_ready;
  assign in_payload  = {in_data, in_empty, in_endofpacket, in_startofpacket};
  assign buf_out_rdy = {out1_ready, out0_ready};

  for (genvar g = 0; g < 2; g++) begin : g_out
    assign buf_wr[g] = accept && (sel == 1'(g)) && buf_rdy[g];

    monitor_capture_demux_skid #(
      .PAYLOAD_WIDTH (PW)
    ) u_skid (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (buf_wr[g]),
      .in_ready    (buf_rdy[g]),
      .in_payload  (in_payload),
      .out_valid   (buf_vld[g]),
      .out_ready   (buf_out_rdy[g]),
      .out_payload (buf_out[g]),
      .count       (buf_cnt[g])
    );
  end

  // Route state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RT_IDLE;
    else       state <= state_nxt;
  end

  // Next route state: any accepted beat enters/stays in a packet unless EOP.
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = in_endofpacket ? RT_IDLE : RT_PKT;
  end

  // Destination latch; sel already equals dest on non-SOP in-packet beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       dest <= 1'b0;
    else if (accept) dest <= sel;
  end

  // Per-output packet counters, bumped on each EOP written to that buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pkt_cnt <= '0;
    else if (accept && in_endofpacket)
      pkt_cnt[sel] <= pkt_cnt[sel] + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Sticky framing error: missing SOP between packets, or SOP inside one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ferr <= 1'b0;
    else if (accept && ((state == RT_IDLE && !in_startofpacket) ||
                        (state == RT_PKT  &&  in_startofpacket)))
      ferr <= 1'b1;
  end

  assign out0_valid         = buf_vld[0];
  assign out0_data          = buf_out[0][PW-1 -: DATA_WIDTH];
  assign out0_empty         = buf_out[0][FLD_EMPTY +: EMPTY_WIDTH];
  assign out0_endofpacket   = buf_out[0][FLD_EOP];
  assign out0_startofpacket = buf_out[0][FLD_SOP];
  assign out1_valid         = buf_vld[1];
  assign out1_data          = buf_out[1][PW-1 -: DATA_WIDTH];
  assign out1_empty         = buf_out[1][FLD_EMPTY +: EMPTY_WIDTH];
  assign out1_endofpacket   = buf_out[1][FLD_EOP];
  assign out1_startofpacket = buf_out[1][FLD_SOP];
  assign pkt_count0         = pkt_cnt[0];
  assign pkt_count1         = pkt_cnt[1];
  assign framing_err        = ferr;

endmodule
